aqp_vmode_ctrl: RTL and testbench



---
 rtl/aqp_vmode_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_aqp_vmode_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/aqp_vmode_ctrl.sv
// aqp_vmode_ctrl
//
// Sequences a glitch-free switch of the video pixel clock between mode 0
// (28.63636 MHz) and mode 1 (25.175 MHz) by driving the BUFGMUX select.
// Video timing is held in reset (blanked) around every select change. The
// controller waits for PLL lock before selecting the synthesized clock, and
// it falls back to mode 0 on lock timeout or on loss of lock.
//
// Ports:
//   clk         in  system clock (28.63636 MHz, not muxed)
//   reset       in  asynchronous, active-high reset
//   mode_req    in  requested video mode (level) from the register file
//   pll_locked  in  PLL lock, asynchronous to clk (2-FF synchronised here)
//   err_clr     in  one-cycle pulse that clears err
//   video_mode  out BUFGMUX select: 0 = 28.6 MHz, 1 = 25.175 MHz
//   video_reset out holds video timing in reset and forces blanking
//   busy        out high whenever a switch sequence is in progress
//   done        out one-cycle pulse when a switch sequence completes
//   err         out sticky lock-timeout / lock-loss flag
//
// Every output is registered.

module aqp_vmode_ctrl #(
  parameter int unsigned BLANK_CYCLES  = 16,    // >= 1
  parameter int unsigned SETTLE_CYCLES = 64,    // >= 1
  parameter int unsigned LOCK_TIMEOUT  = 65535  // 1 .. 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic mode_req,
  input  logic pll_locked,
  input  logic err_clr,
  output logic video_mode,
  output logic video_reset,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BLANK,
    S_WAIT_LOCK,
    S_SWITCH,
    S_SETTLE
  } state_t;

  localparam logic [15:0] BLANK_LD  = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] LOCK_LD   = 16'(LOCK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        target_q, target_d;
  logic        lock_meta_q, lock_s_q;
  logic        video_mode_q, video_mode_d;
  logic        video_reset_q, video_reset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        err_set;

  // State register, counter, lock synchroniser and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      target_q      <= 1'b0;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      video_mode_q  <= 1'b0;
      video_reset_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      lock_meta_q   <= pll_locked;
      lock_s_q      <= lock_meta_q;
      video_mode_q  <= video_mode_d;
      video_reset_q <= video_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  // Next-state, counter and target selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    err_set  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Lock loss while running on the synthesized clock takes priority
        // and forces a fall back to mode 0.
        if (!lock_s_q && video_mode_q) begin
          err_set  = 1'b1;
          target_d = 1'b0;
          state_d  = S_BLANK;
          cnt_d    = BLANK_LD;
        end else if ((mode_req != video_mode_q) && !(mode_req && err_q)) begin
          target_d = mode_req;
          state_d  = S_BLANK;
          cnt_d    = BLANK_LD;
        end
      end
      S_BLANK: begin
        if (cnt_q == '0) begin
          if (target_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = LOCK_LD;
          end else begin
            state_d = S_SWITCH;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_SWITCH;
        end else if (cnt_q == '0) begin
          // Timed out: switch anyway but to mode 0, which leaves the
          // select unchanged if it is already 0.
          err_set  = 1'b1;
          target_d = 1'b0;
          state_d  = S_SWITCH;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_SWITCH: begin
        state_d = S_SETTLE;
        cnt_d   = SETTLE_LD;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next-values; outputs are registered, so they are derived from
  // the upcoming state to line up with the state they describe.
  always_comb begin
    video_mode_d  = video_mode_q;
    video_reset_d = (state_d != S_IDLE);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_q == S_SETTLE) && (state_d == S_IDLE);
    err_d         = err_q;
    if (state_q == S_SWITCH) begin
      video_mode_d = target_q;
    end
    // A clear and a set in the same cycle resolve to set.
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (err_set) begin
      err_d = 1'b1;
    end
  end

  assign video_mode  = video_mode_q;
  assign video_reset = video_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_aqp_vmode_ctrl.sv
module tb_aqp_vmode_ctrl;

  logic clk;
  logic reset;
  logic mode_req;
  logic pll_locked;
  logic err_clr;
  logic video_mode;
  logic video_reset;
  logic busy;
  logic done;
  logic err;

  int unsigned checks;
  int unsigned errors;

  aqp_vmode_ctrl #(
    .BLANK_CYCLES (16),
    .SETTLE_CYCLES(64),
    .LOCK_TIMEOUT (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_req   (mode_req),
    .pll_locked (pll_locked),
    .err_clr    (err_clr),
    .video_mode (video_mode),
    .video_reset(video_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns after the last one.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    mode_req   = 1'b0;
    pll_locked = 1'b1;
    err_clr    = 1'b0;

    // Reset state
    step(2);
    chk("rst_video_mode", video_mode, 1'b0);
    chk("rst_video_reset", video_reset, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b0;
    step(3);
    chk("idle_busy", busy, 1'b0);

    // Mode 0 -> 1, lock steady. Edge N is the first edge after mode_req.
    mode_req = 1'b1;
    step(1);                                   // N
    chk("m01_busy_N", busy, 1'b1);
    chk("m01_vrst_N", video_reset, 1'b1);
    chk("m01_vmode_N", video_mode, 1'b0);
    step(17);                                  // N+17
    chk("m01_vmode_N17", video_mode, 1'b0);
    step(1);                                   // N+18
    chk("m01_vmode_N18", video_mode, 1'b1);
    chk("m01_vrst_N18", video_reset, 1'b1);
    step(63);                                  // N+81
    chk("m01_done_N81", done, 1'b0);
    chk("m01_vrst_N81", video_reset, 1'b1);
    step(1);                                   // N+82
    chk("m01_done_N82", done, 1'b1);
    chk("m01_vrst_N82", video_reset, 1'b0);
    chk("m01_vmode_N82", video_mode, 1'b1);
    step(1);                                   // N+83
    chk("m01_done_N83", done, 1'b0);
    chk("m01_busy_N83", busy, 1'b0);
    chk("m01_err", err, 1'b0);

    // Mode 1 -> 0: no WAIT_LOCK, select changes at N+17.
    mode_req = 1'b0;
    step(1);                                   // N
    chk("m10_busy_N", busy, 1'b1);
    step(16);                                  // N+16
    chk("m10_vmode_N16", video_mode, 1'b1);
    step(1);                                   // N+17
    chk("m10_vmode_N17", video_mode, 1'b0);
    step(63);                                  // N+80
    chk("m10_done_N80", done, 1'b0);
    step(1);                                   // N+81
    chk("m10_done_N81", done, 1'b1);
    chk("m10_vrst_N81", video_reset, 1'b0);
    step(1);
    chk("m10_done_off", done, 1'b0);
    chk("m10_busy_off", busy, 1'b0);

    // Lock timeout (LOCK_TIMEOUT = 100), then retry after err_clr.
    pll_locked = 1'b0;
    step(3);
    chk("to_idle_busy", busy, 1'b0);
    chk("to_idle_err", err, 1'b0);
    mode_req = 1'b1;
    step(1);                                   // N
    chk("to_busy_N", busy, 1'b1);
    step(115);                                 // N+115
    chk("to_err_N115", err, 1'b0);
    step(1);                                   // N+116
    chk("to_err_N116", err, 1'b1);
    chk("to_vmode_N116", video_mode, 1'b0);
    step(1);                                   // N+117
    chk("to_vmode_N117", video_mode, 1'b0);
    step(63);                                  // N+180
    chk("to_done_N180", done, 1'b0);
    step(1);                                   // N+181
    chk("to_done_N181", done, 1'b1);
    chk("to_vmode_N181", video_mode, 1'b0);
    chk("to_err_N181", err, 1'b1);
    step(3);
    chk("to_req_ignored", busy, 1'b0);
    pll_locked = 1'b1;
    step(3);
    chk("to_still_ignored", busy, 1'b0);
    err_clr = 1'b1;
    step(1);                                   // M
    err_clr = 1'b0;
    chk("retry_err_clr", err, 1'b0);
    chk("retry_busy_M", busy, 1'b0);
    step(1);                                   // S = M+1
    chk("retry_busy_S", busy, 1'b1);
    step(17);                                  // S+17
    chk("retry_vmode_S17", video_mode, 1'b0);
    step(1);                                   // S+18
    chk("retry_vmode_S18", video_mode, 1'b1);
    step(64);                                  // S+82
    chk("retry_done_S82", done, 1'b1);
    step(1);
    chk("retry_busy_off", busy, 1'b0);

    // Lock loss in mode 1 IDLE; err_clr coincides with the set edge.
    pll_locked = 1'b0;
    step(1);                                   // E+1
    chk("ll_err_E1", err, 1'b0);
    step(1);                                   // E+2
    chk("ll_err_E2", err, 1'b0);
    chk("ll_busy_E2", busy, 1'b0);
    err_clr = 1'b1;
    step(1);                                   // E+3 = S
    err_clr = 1'b0;
    chk("ll_err_set_wins", err, 1'b1);
    chk("ll_busy_S", busy, 1'b1);
    chk("ll_vrst_S", video_reset, 1'b1);
    step(16);                                  // S+16
    chk("ll_vmode_S16", video_mode, 1'b1);
    step(1);                                   // S+17
    chk("ll_vmode_S17", video_mode, 1'b0);
    step(64);                                  // S+81
    chk("ll_done_S81", done, 1'b1);
    chk("ll_err_S81", err, 1'b1);
    pll_locked = 1'b1;
    step(5);
    chk("ll_no_rehonour_busy", busy, 1'b0);
    chk("ll_no_rehonour_vmode", video_mode, 1'b0);
    mode_req = 1'b0;
    err_clr  = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("ll_err_cleared", err, 1'b0);
    step(3);
    chk("ll_idle_busy", busy, 1'b0);

    // Mid-sequence request change: 0->1 then back to 0 during BLANK.
    mode_req = 1'b1;
    step(1);                                   // N
    chk("mid_busy_N", busy, 1'b1);
    step(2);                                   // N+2
    mode_req = 1'b0;
    step(16);                                  // N+18
    chk("mid_vmode_N18", video_mode, 1'b1);
    step(64);                                  // N+82
    chk("mid_done_N82", done, 1'b1);
    chk("mid_vrst_N82", video_reset, 1'b0);
    step(1);                                   // N+83: second sequence starts
    chk("mid_busy_N83", busy, 1'b1);
    chk("mid_vrst_N83", video_reset, 1'b1);
    chk("mid_done_N83", done, 1'b0);
    step(17);                                  // N+100
    chk("mid_vmode_N100", video_mode, 1'b0);
    step(64);                                  // N+164
    chk("mid_done_N164", done, 1'b1);
    step(1);

    // Asynchronous reset during SETTLE.
    mode_req = 1'b1;
    step(1);                                   // N
    step(30);                                  // N+31, in SETTLE
    chk("ar_pre_vmode", video_mode, 1'b1);
    chk("ar_pre_busy", busy, 1'b1);
    mode_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_vmode", video_mode, 1'b0);
    chk("ar_vrst", video_reset, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_done", done, 1'b0);
    step(2);
    reset = 1'b0;
    step(3);
    chk("ar_after_busy", busy, 1'b0);
    chk("ar_after_vmode", video_mode, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
